// File: rtl/fm1808_responder_if.sv
// -----------------------------------------------------------------------------
// fm1808_responder_if
// Strobe, address and data bundle between the memory-cycle sequence generator
// (master) and the FM1808 NVRAM responder (slave).
//   ce_n, we_n, oe_n : active-low chip enable / write enable / output enable
//   addr             : address bus
//   data_in          : data bus as seen by the chip (write data)
//   data_out         : read data from the responder
//   data_oe          : drive enable for the external tristate data buffer
//   busy             : responder is inside a memory cycle
//   precharge_err    : sticky, /CE fell before precharge expired
//   bus_err          : sticky, /WE and /OE low together while /CE low
//   clear_err        : single-cycle pulse clearing both sticky flags
// -----------------------------------------------------------------------------
interface fm1808_responder_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic                  ce_n;
  logic                  we_n;
  logic                  oe_n;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_oe;
  logic                  busy;
  logic                  precharge_err;
  logic                  bus_err;
  logic                  clear_err;

  modport master (
    output ce_n, we_n, oe_n, addr, data_in, clear_err,
    input  data_out, data_oe, busy, precharge_err, bus_err
  );

  modport slave (
    input  ce_n, we_n, oe_n, addr, data_in, clear_err,
    output data_out, data_oe, busy, precharge_err, bus_err
  );
endinterface

// File: rtl/fm1808_responder.sv
// -----------------------------------------------------------------------------
// fm1808_responder
// Cycle-level behavioural stand-in for the FM1808 32Kx8 NVRAM. Synchronizes the
// asynchronous /CE, /WE, /OE strobes, services reads and writes to an internal
// block RAM and flags protocol violations. Memory contents survive reset.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : fm1808_responder_if.slave (strobes, address, data, status, clear)
// -----------------------------------------------------------------------------
module fm1808_responder #(
  parameter int ADDR_WIDTH       = 15,
  parameter int DATA_WIDTH       = 8,
  parameter int ACCESS_CYCLES    = 4,
  parameter int PRECHARGE_CYCLES = 3
) (
  input logic               clk,
  input logic               reset,
  fm1808_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ACTIVE     = 3'd1,
    WRITE      = 3'd2,
    READ_WAIT  = 3'd3,
    READ_DRIVE = 3'd4,
    PRECHARGE  = 3'd5,
    IGNORE     = 3'd6
  } state_t;

  localparam logic [3:0] ACCESS_LOAD    = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] PRECHARGE_LOAD = 4'(PRECHARGE_CYCLES - 1);

  logic                  ce_meta_r, ce_sync_r;
  logic                  we_meta_r, we_sync_r;
  logic                  oe_meta_r, oe_sync_r;
  logic [1:0]            sync_valid_r;
  logic                  armed_r;
  logic                  ce_prev_r;
  logic                  ce_fall_s;

  state_t                state_r, next_state_s;
  logic [3:0]            cnt_r, next_cnt_s;
  logic [ADDR_WIDTH-1:0] addr_lat_r;
  logic [ADDR_WIDTH-1:0] rd_addr_s;

  logic                  start_s;
  logic                  enter_read_s;
  logic                  latch_s;
  logic                  wr_en_s;
  logic                  rd_en_s;
  logic                  pre_err_set_s;
  logic                  conflict_s;

  logic [DATA_WIDTH-1:0] mem_r [0:(2**ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  data_oe_r;
  logic                  busy_r;
  logic                  precharge_err_r;
  logic                  bus_err_r;

  // Two-flop strobe synchronizers; reset high so strobes look inactive.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_meta_r    <= 1'b1;
      ce_sync_r    <= 1'b1;
      we_meta_r    <= 1'b1;
      we_sync_r    <= 1'b1;
      oe_meta_r    <= 1'b1;
      oe_sync_r    <= 1'b1;
      sync_valid_r <= 2'b00;
    end else begin
      ce_meta_r    <= bus.ce_n;
      ce_sync_r    <= ce_meta_r;
      we_meta_r    <= bus.we_n;
      we_sync_r    <= we_meta_r;
      oe_meta_r    <= bus.oe_n;
      oe_sync_r    <= oe_meta_r;
      sync_valid_r <= {sync_valid_r[0], 1'b1};
    end
  end

  // /CE fall detector. The sync flops come out of reset at 1, which would fake
  // a high level; arming waits until the chain carries real pin data and shows
  // /CE high, so a /CE held low across reset is not taken as a new cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      armed_r   <= 1'b0;
      ce_prev_r <= 1'b1;
    end else begin
      armed_r   <= armed_r | (sync_valid_r[1] & ce_sync_r);
      ce_prev_r <= ce_sync_r;
    end
  end

  assign ce_fall_s = armed_r & ce_prev_r & ~ce_sync_r;

  // Next-state, counter and datapath strobes.
  always_comb begin
    next_state_s  = state_r;
    next_cnt_s    = cnt_r;
    start_s       = 1'b0;
    enter_read_s  = 1'b0;
    latch_s       = 1'b0;
    wr_en_s       = 1'b0;
    pre_err_set_s = 1'b0;
    conflict_s    = 1'b0;

    case (state_r)
      IDLE: begin
        if (ce_fall_s) begin
          start_s = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACTIVE: begin
        if (ce_sync_r) begin
          next_state_s = PRECHARGE;
          next_cnt_s   = PRECHARGE_LOAD;
        end else if (!we_sync_r) begin
          next_state_s = WRITE;
        end else if (!oe_sync_r) begin
          enter_read_s = 1'b1;
        end else begin
          next_state_s = ACTIVE;
        end
      end
      WRITE: begin
        // Either terminating edge commits the write; a /CE rise still writes.
        if (we_sync_r || ce_sync_r) begin
          wr_en_s = 1'b1;
          if (ce_sync_r) begin
            next_state_s = PRECHARGE;
            next_cnt_s   = PRECHARGE_LOAD;
          end else begin
            next_state_s = ACTIVE;
          end
        end else begin
          next_state_s = WRITE;
        end
      end
      READ_WAIT: begin
        if (!we_sync_r) begin
          next_state_s = WRITE;
        end else if (ce_sync_r) begin
          next_state_s = PRECHARGE;
          next_cnt_s   = PRECHARGE_LOAD;
        end else if (oe_sync_r) begin
          next_state_s = ACTIVE;
        end else if (cnt_r == 4'd1) begin
          // Counter reaches zero on this edge: data goes out together with it.
          next_state_s = READ_DRIVE;
          next_cnt_s   = 4'd0;
        end else begin
          next_cnt_s = cnt_r - 4'd1;
        end
      end
      READ_DRIVE: begin
        if (!we_sync_r) begin
          next_state_s = WRITE;
        end else if (ce_sync_r) begin
          next_state_s = PRECHARGE;
          next_cnt_s   = PRECHARGE_LOAD;
        end else if (oe_sync_r) begin
          next_state_s = ACTIVE;
        end else begin
          next_state_s = READ_DRIVE;
        end
      end
      PRECHARGE: begin
        // /CE low here is always a new fall; legal only once the count expired.
        if (!ce_sync_r) begin
          if (cnt_r == 4'd0) begin
            start_s = 1'b1;
          end else begin
            pre_err_set_s = 1'b1;
            next_state_s  = IGNORE;
          end
        end else if (cnt_r == 4'd0) begin
          next_state_s = IDLE;
        end else begin
          next_cnt_s = cnt_r - 4'd1;
        end
      end
      IGNORE: begin
        if (ce_sync_r) begin
          next_state_s = PRECHARGE;
          next_cnt_s   = PRECHARGE_LOAD;
        end else begin
          next_state_s = IGNORE;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = 4'd0;
      end
    endcase

    // A new cycle latches the address and dispatches on the strobes at once,
    // so a /OE that fell with /CE counts its access time from the OeS fall.
    if (start_s) begin
      latch_s = 1'b1;
      if (!we_sync_r) begin
        next_state_s = WRITE;
      end else if (!oe_sync_r) begin
        enter_read_s = 1'b1;
      end else begin
        next_state_s = ACTIVE;
      end
    end else begin
      latch_s = 1'b0;
    end

    if (enter_read_s) begin
      if (ACCESS_CYCLES == 1) begin
        next_state_s = READ_DRIVE;
        next_cnt_s   = 4'd0;
      end else begin
        next_state_s = READ_WAIT;
        next_cnt_s   = ACCESS_LOAD;
      end
    end else begin
      enter_read_s = 1'b0;
    end

    if (!ce_sync_r && !we_sync_r && !oe_sync_r &&
        (start_s || state_r == ACTIVE || state_r == WRITE ||
         state_r == READ_WAIT || state_r == READ_DRIVE)) begin
      conflict_s = 1'b1;
    end else begin
      conflict_s = 1'b0;
    end
  end

  assign rd_en_s   = (next_state_s == READ_DRIVE) && (state_r != READ_DRIVE);
  assign rd_addr_s = latch_s ? bus.addr : addr_lat_r;

  // State register, cycle counter and address latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_lat_r <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      if (latch_s) begin
        addr_lat_r <= bus.addr;
      end
    end
  end

  // Registered status outputs and sticky error flags (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      data_oe_r       <= 1'b0;
      busy_r          <= 1'b0;
      precharge_err_r <= 1'b0;
      bus_err_r       <= 1'b0;
    end else begin
      data_oe_r <= (next_state_s == READ_DRIVE) && !conflict_s;
      busy_r    <= (next_state_s != IDLE);
      if (pre_err_set_s) begin
        precharge_err_r <= 1'b1;
      end else if (bus.clear_err) begin
        precharge_err_r <= 1'b0;
      end
      if (conflict_s) begin
        bus_err_r <= 1'b1;
      end else if (bus.clear_err) begin
        bus_err_r <= 1'b0;
      end
    end
  end

  // RAM read port, registered on entry to READ_DRIVE so data is stable there.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_r <= '0;
    end else if (rd_en_s) begin
      data_out_r <= mem_r[rd_addr_s];
    end
  end

  // RAM write port; no reset so contents persist like the real NVRAM.
  always_ff @(posedge clk) begin
    if (wr_en_s && !reset) begin
      mem_r[addr_lat_r] <= bus.data_in;
    end
  end

  assign bus.data_out      = data_out_r;
  assign bus.data_oe       = data_oe_r;
  assign bus.busy          = busy_r;
  assign bus.precharge_err = precharge_err_r;
  assign bus.bus_err       = bus_err_r;

endmodule

// File: tb/tb_fm1808_responder.sv
// -----------------------------------------------------------------------------
// tb_fm1808_responder
// Directed bench for fm1808_responder (AccessCycles=4, PrechargeCycles=3).
// Pins are changed 1 ns after a rising edge ("at clock n") and outputs are
// sampled 1 ns after a rising edge.
// -----------------------------------------------------------------------------
module tb_fm1808_responder;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;
  logic oe_seen;

  fm1808_responder_if bus_if ();

  fm1808_responder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    oe_seen = oe_seen | bus_if.data_oe;
  endtask

  // Plain read cycle: /CE and /OE low together, sample 6 clocks later.
  task automatic read_cycle(input logic [14:0] a, output logic [7:0] d, output logic oe);
    bus_if.addr = a;
    bus_if.ce_n = 1'b0;
    bus_if.oe_n = 1'b0;
    repeat (6) tick();
    oe = bus_if.data_oe;
    d  = bus_if.data_out;
    bus_if.oe_n = 1'b1;
    repeat (3) tick();
    bus_if.ce_n = 1'b1;
    repeat (6) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (bus_if.data_out !== 8'h00) begin
      $display("FAIL reset_data_out: got %h want 00", bus_if.data_out); n_bad++;
    end
    n_cmp++;
    if (bus_if.data_oe !== 1'b0) begin
      $display("FAIL reset_data_oe: got %b want 0", bus_if.data_oe); n_bad++;
    end
    n_cmp++;
    if (bus_if.busy !== 1'b0) begin
      $display("FAIL reset_busy: got %b want 0", bus_if.busy); n_bad++;
    end
    n_cmp++;
    if (bus_if.precharge_err !== 1'b0 || bus_if.bus_err !== 1'b0) begin
      $display("FAIL reset_errs: got pre=%b bus=%b want 0 0",
               bus_if.precharge_err, bus_if.bus_err); n_bad++;
    end
    reset = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_write();
    oe_seen = 1'b0;
    bus_if.addr = 15'h1234;
    bus_if.ce_n = 1'b0;
    tick();
    bus_if.we_n    = 1'b0;
    bus_if.data_in = 8'h5A;
    repeat (4) tick();
    n_cmp++;
    if (bus_if.busy !== 1'b1) begin
      $display("FAIL write_busy: got %b want 1", bus_if.busy); n_bad++;
    end
    bus_if.we_n = 1'b1;
    repeat (4) tick();
    bus_if.ce_n = 1'b1;
    repeat (7) tick();
    n_cmp++;
    if (oe_seen !== 1'b0) begin
      $display("FAIL write_no_oe: got %b want 0", oe_seen); n_bad++;
    end
    n_cmp++;
    if (bus_if.precharge_err !== 1'b0 || bus_if.bus_err !== 1'b0) begin
      $display("FAIL write_errs: got pre=%b bus=%b want 0 0",
               bus_if.precharge_err, bus_if.bus_err); n_bad++;
    end
    n_cmp++;
    if (bus_if.busy !== 1'b0) begin
      $display("FAIL write_idle: got %b want 0", bus_if.busy); n_bad++;
    end
  endtask

  // Ends with /CE raised and no wait, leaving the precharge test to follow.
  task automatic test_read();
    bus_if.addr = 15'h1234;
    bus_if.ce_n = 1'b0;
    bus_if.oe_n = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (bus_if.data_oe !== 1'b0) begin
      $display("FAIL read_oe_early: got %b want 0 at n+5", bus_if.data_oe); n_bad++;
    end
    tick();
    n_cmp++;
    if (bus_if.data_oe !== 1'b1) begin
      $display("FAIL read_oe_on: got %b want 1 at n+6", bus_if.data_oe); n_bad++;
    end
    n_cmp++;
    if (bus_if.data_out !== 8'h5A) begin
      $display("FAIL read_data: got %h want 5a", bus_if.data_out); n_bad++;
    end
    repeat (3) tick();
    n_cmp++;
    if (bus_if.data_oe !== 1'b1 || bus_if.data_out !== 8'h5A) begin
      $display("FAIL read_hold: got oe=%b data=%h want 1 5a",
               bus_if.data_oe, bus_if.data_out); n_bad++;
    end
    bus_if.oe_n = 1'b1;
    repeat (2) tick();
    n_cmp++;
    if (bus_if.data_oe !== 1'b1) begin
      $display("FAIL read_oe_m2: got %b want 1 at m+2", bus_if.data_oe); n_bad++;
    end
    tick();
    n_cmp++;
    if (bus_if.data_oe !== 1'b0) begin
      $display("FAIL read_oe_off: got %b want 0 at m+3", bus_if.data_oe); n_bad++;
    end
    bus_if.ce_n = 1'b1;
  endtask

  task automatic test_precharge_violation();
    logic [7:0] d;
    logic       oe;
    tick();
    bus_if.ce_n = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus_if.precharge_err !== 1'b1) begin
      $display("FAIL pre_err_set: got %b want 1", bus_if.precharge_err); n_bad++;
    end
    bus_if.we_n    = 1'b0;
    bus_if.data_in = 8'hEE;
    repeat (4) tick();
    bus_if.we_n = 1'b1;
    repeat (4) tick();
    n_cmp++;
    if (bus_if.busy !== 1'b1) begin
      $display("FAIL pre_ignore_busy: got %b want 1", bus_if.busy); n_bad++;
    end
    bus_if.clear_err = 1'b1;
    tick();
    bus_if.clear_err = 1'b0;
    n_cmp++;
    if (bus_if.precharge_err !== 1'b0) begin
      $display("FAIL pre_err_clear: got %b want 0", bus_if.precharge_err); n_bad++;
    end
    bus_if.ce_n = 1'b1;
    repeat (5) tick();
    read_cycle(15'h1234, d, oe);
    n_cmp++;
    if (oe !== 1'b1 || d !== 8'h5A) begin
      $display("FAIL pre_mem_kept: got oe=%b data=%h want 1 5a", oe, d); n_bad++;
    end
  endtask

  task automatic test_ce_terminated_write();
    logic [7:0] d;
    logic       oe;
    bus_if.addr = 15'h0001;
    bus_if.ce_n = 1'b0;
    tick();
    bus_if.we_n    = 1'b0;
    bus_if.data_in = 8'hC3;
    repeat (3) tick();
    bus_if.ce_n = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (bus_if.busy !== 1'b1) begin
      $display("FAIL cew_precharge_busy: got %b want 1 at e+5", bus_if.busy); n_bad++;
    end
    tick();
    n_cmp++;
    if (bus_if.busy !== 1'b0) begin
      $display("FAIL cew_idle: got %b want 0 at e+6", bus_if.busy); n_bad++;
    end
    bus_if.we_n = 1'b1;
    repeat (3) tick();
    bus_if.data_in = 8'h00;
    read_cycle(15'h0001, d, oe);
    n_cmp++;
    if (oe !== 1'b1 || d !== 8'hC3) begin
      $display("FAIL cew_data: got oe=%b data=%h want 1 c3", oe, d); n_bad++;
    end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    logic       oe;
    oe_seen        = 1'b0;
    bus_if.addr    = 15'h0002;
    bus_if.data_in = 8'h77;
    bus_if.ce_n    = 1'b0;
    bus_if.oe_n    = 1'b0;
    repeat (2) tick();
    bus_if.we_n = 1'b0;
    repeat (2) tick();
    bus_if.oe_n = 1'b1;
    repeat (2) tick();
    bus_if.we_n = 1'b1;
    repeat (4) tick();
    bus_if.ce_n = 1'b1;
    repeat (6) tick();
    n_cmp++;
    if (bus_if.bus_err !== 1'b1) begin
      $display("FAIL conflict_bus_err: got %b want 1", bus_if.bus_err); n_bad++;
    end
    n_cmp++;
    if (oe_seen !== 1'b0) begin
      $display("FAIL conflict_no_oe: got %b want 0", oe_seen); n_bad++;
    end
    bus_if.clear_err = 1'b1;
    tick();
    bus_if.clear_err = 1'b0;
    n_cmp++;
    if (bus_if.bus_err !== 1'b0) begin
      $display("FAIL conflict_clear: got %b want 0", bus_if.bus_err); n_bad++;
    end
    read_cycle(15'h0002, d, oe);
    n_cmp++;
    if (oe !== 1'b1 || d !== 8'h77) begin
      $display("FAIL conflict_write_done: got oe=%b data=%h want 1 77", oe, d); n_bad++;
    end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d;
    logic       oe;
    bus_if.addr = 15'h1234;
    bus_if.ce_n = 1'b0;
    bus_if.oe_n = 1'b0;
    repeat (7) tick();
    n_cmp++;
    if (bus_if.data_oe !== 1'b1) begin
      $display("FAIL rst_pre_drive: got %b want 1", bus_if.data_oe); n_bad++;
    end
    reset = 1'b1;
    tick();
    n_cmp++;
    if (bus_if.data_oe !== 1'b0 || bus_if.busy !== 1'b0 || bus_if.data_out !== 8'h00) begin
      $display("FAIL rst_mid_read: got oe=%b busy=%b data=%h want 0 0 00",
               bus_if.data_oe, bus_if.busy, bus_if.data_out); n_bad++;
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (8) tick();
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.data_oe !== 1'b0) begin
      $display("FAIL rst_ce_low_ignored: got busy=%b oe=%b want 0 0",
               bus_if.busy, bus_if.data_oe); n_bad++;
    end
    bus_if.ce_n = 1'b1;
    bus_if.oe_n = 1'b1;
    repeat (4) tick();
    read_cycle(15'h1234, d, oe);
    n_cmp++;
    if (oe !== 1'b1 || d !== 8'h5A) begin
      $display("FAIL rst_mem_kept: got oe=%b data=%h want 1 5a", oe, d); n_bad++;
    end
  endtask

  initial begin
    n_cmp            = 0;
    n_bad            = 0;
    oe_seen          = 1'b0;
    reset            = 1'b1;
    bus_if.ce_n      = 1'b1;
    bus_if.we_n      = 1'b1;
    bus_if.oe_n      = 1'b1;
    bus_if.addr      = 15'h0000;
    bus_if.data_in   = 8'h00;
    bus_if.clear_err = 1'b0;

    test_reset();
    test_write();
    test_read();
    test_precharge_violation();
    test_ce_terminated_write();
    test_conflict();
    test_reset_mid_read();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fm1808_responder.md
Name: fm1808_responder

Overview:
- Cycle-level behavioural responder for the FM1808 32Kx8 NVRAM. It sits on the far end of the /CE, /WE, /OE strobes that the memory-cycle sequence generator drives.
- It lets the sequence generator and the board bus be exercised on the TinyFPGA without the real chip, and it flags protocol violations.
- All strobe, address and data pins are asynchronous to Clk and are synchronized internally.
- Memory contents survive Reset, mirroring non-volatile storage.

Parameters:
AddrWidth, 15, address bits (32K locations)
DataWidth, 8, data bits
AccessCycles, 4, clocks from synchronized /OE low (with /CE low, /WE high) to data driven; range 1-15
PrechargeCycles, 3, minimum clocks synchronized /CE must stay high between cycles; range 1-15

Ports:
Clk  input  1  system clock (16 MHz)
Reset  input  1  synchronous, active-high reset
CE_n  input  1  chip enable, active low, asynchronous
WE_n  input  1  write enable, active low, asynchronous
OE_n  input  1  output enable, active low, asynchronous
Addr  input  AddrWidth  address bus
DataIn  input  DataWidth  data bus as seen by the chip (write data)
DataOut  output  DataWidth  read data
DataOe  output  1  drive enable for the external tristate data buffer
Busy  output  1  high while a cycle is in progress (state not IDLE)
PrechargeErr  output  1  sticky: /CE fell before precharge expired
BusErr  output  1  sticky: /WE and /OE low together while /CE low
ClearErr  input  1  single-cycle pulse that clears both sticky flags

Behaviour:
- Synchronizers: CE_n, WE_n and OE_n each pass through a 2-flop synchronizer (CeS, WeS, OeS). Sync flops reset to 1. A pin edge at clock n is visible as a CeS/WeS/OeS edge at clock n+2.
- Address latch:
  - On a CeS falling edge in IDLE, Addr is captured into AddrLat and the state goes to ACTIVE.
  - Addr must be held 3 clocks after the pin falls.
- States:
  - IDLE (Busy=0). CeS fall -> ACTIVE.
  - ACTIVE. WeS low -> WRITE. OeS low with WeS high -> READ_WAIT. CeS rise -> PRECHARGE.
  - WRITE:
    - A WeS rise stores DataIn at mem[AddrLat] and returns to ACTIVE.
    - A CeS rise while WeS is still low stores and goes to PRECHARGE; this write takes priority over the CeS rise.
    - DataIn must be held 3 clocks after the terminating pin edge.
    - Exactly one write occurs per /WE low pulse.
  - READ_WAIT:
    - A counter loads AccessCycles-1 and decrements.
    - At zero it goes to READ_DRIVE, and DataOe=1 with DataOut=mem[AddrLat] in the same cycle.
    - DataOe therefore asserts AccessCycles clocks after the OeS fall.
    - OeS high -> ACTIVE. CeS high -> PRECHARGE.
  - READ_DRIVE:
    - Holds DataOe=1 and DataOut stable.
    - When OeS rises or CeS rises, DataOe drops at the next clock and the state goes to ACTIVE or PRECHARGE respectively.
  - PRECHARGE:
    - A counter loads PrechargeCycles-1 and the state goes to IDLE at zero.
    - A CeS fall before then sets PrechargeErr and goes to IGNORE.
  - IGNORE (Busy=1):
    - No read, write or address latch takes place.
    - A CeS rise -> PRECHARGE with the counter reloaded.
- Conflict:
  - In any /CE-low state, WeS=0 and OeS=0 together sets BusErr and forces DataOe=0 the next clock.
  - The write path still completes normally.
  - A READ_WAIT that sees WeS fall goes to WRITE.
- Sticky flags:
  - Set and ClearErr in the same cycle: set wins.
  - ClearErr otherwise clears both flags the next clock.
- Reset, including mid-cycle:
  - Outputs reset to DataOut=0, DataOe=0, Busy=0, PrechargeErr=0, BusErr=0.
  - State goes to IDLE, counters and AddrLat to 0, and sync flops to 1.
  - A write in progress is discarded.
  - mem is NOT cleared.
  - If the CE_n pin is low when Reset releases, the first CeS fall is not seen; the responder waits for /CE high, then low.
- mem is an inferred block RAM, read-before-output registered. Its contents are undefined until written.
- Ranges: counters are 4 bits. Values outside 1-15 are unsupported.

Test Plan:
1. Write 0x5A to 0x1234: /CE low with Addr=0x1234; 1 clk later /WE low for 4 clks with DataIn=0x5A, held; /WE high, then /CE high -> mem[0x1234]=0x5A, DataOe never 1, no errors.
2. Read back 0x1234, AccessCycles=4: /CE low, /OE low at same clock n -> DataOe=1 and DataOut=0x5A at clock n+6, held while /OE low; /OE high at m -> DataOe=0 at m+3.
3. Precharge violation: after a cycle, /CE high for 1 clk then low -> PrechargeErr=1, no address latch, and a /WE pulse does not modify memory; /CE high for 5 clks then a good cycle proceeds normally.
4. /CE-terminated write: /WE held low through the /CE rise, DataIn=0xC3, Addr=0x0001 -> mem[0x0001]=0xC3, single write, state PRECHARGE then IDLE after 3 clks.
5. Conflict: /CE low, /OE low, then /WE low during READ_WAIT -> BusErr=1, DataOe stays 0, write completes; ClearErr pulse -> BusErr=0.
6. Reset mid-read in READ_DRIVE -> DataOe=0 and Busy=0 the next clock; after Reset, a normal read of 0x1234 still returns 0x5A.
